scale_sequencer: RTL and testbench

Note sequencer that plays an 8-note C-major scale by driving the `f_dHz` input of the existing tone generators (`square`, `harmonic_pwm`). It steps through an internal frequency table with programmable note length and a fixed inter-note gap, and outputs a gate that marks when a note is sounding. It supports up/down direction, single-shot or looped playback, and abort. It sits between board controls (buttons/switches) and the sound PWM datapath.

---
 rtl/scale_sequencer.sv | 157 +++++++++++++++
 tb/tb_scale_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/scale_sequencer.sv
// Eight-note C-major scale sequencer feeding f_dHz of the tone generators.
// Plays each note for a programmable length, separated by a fixed silent gap.
module scale_sequencer #(
    parameter int unsigned DIV    = 100_000,
    parameter int unsigned GAP_MS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic        dir,
    input  logic [15:0] note_ms,
    output logic [31:0] f_dHz,
    output logic        gate,
    output logic [2:0]  note_idx,
    output logic        busy,
    output logic        done
);

    // state  | meaning
    // S_IDLE | waiting for start; gate and busy low
    // S_PLAY | note sounding for dur ms ticks
    // S_GAP  | silence for GAP_MS ms ticks, f_dHz held
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    localparam int          PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam bit          HAS_GAP  = (GAP_MS != 0);
    localparam logic [15:0] GAP_LAST = HAS_GAP ? 16'(GAP_MS - 1) : 16'd0;

    state_t      state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [15:0] ms_cnt, ms_nxt;
    logic [15:0] dur, dur_nxt;
    logic        dir_q, dir_nxt;
    logic [2:0]  idx_nxt;
    logic [31:0] f_nxt;
    logic        gate_nxt, busy_nxt, done_nxt;
    logic        tick, advance, last_note;

    function automatic logic [31:0] note_freq(input logic [2:0] i);
        case (i)
            3'd0:    note_freq = 32'd2616;
            3'd1:    note_freq = 32'd2937;
            3'd2:    note_freq = 32'd3296;
            3'd3:    note_freq = 32'd3492;
            3'd4:    note_freq = 32'd3920;
            3'd5:    note_freq = 32'd4400;
            3'd6:    note_freq = 32'd4939;
            default: note_freq = 32'd5233;
        endcase
    endfunction

    assign tick      = (presc == PRE_LAST);
    assign last_note = dir_q ? (note_idx == 3'd0) : (note_idx == 3'd7);

    always_comb begin
        state_nxt = state;
        presc_nxt = tick ? '0 : presc + PW'(1);
        ms_nxt    = tick ? ms_cnt + 16'd1 : ms_cnt;
        dur_nxt   = dur;
        dir_nxt   = dir_q;
        idx_nxt   = note_idx;
        f_nxt     = f_dHz;
        done_nxt  = 1'b0;
        advance   = 1'b0;

        case (state)
            S_IDLE: begin
                presc_nxt = '0;
                ms_nxt    = '0;
                if (start) begin
                    state_nxt = S_PLAY;
                    dir_nxt   = dir;
                    dur_nxt   = (note_ms == 16'd0) ? 16'd1 : note_ms;
                    idx_nxt   = dir ? 3'd7 : 3'd0;
                    f_nxt     = note_freq(dir ? 3'd7 : 3'd0);
                end
            end
            S_PLAY: begin
                if (tick && ms_cnt == dur - 16'd1) begin
                    if (HAS_GAP) begin
                        state_nxt = S_GAP;
                        presc_nxt = '0;
                        ms_nxt    = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tick && ms_cnt == GAP_LAST) advance = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (advance) begin
            presc_nxt = '0;
            ms_nxt    = '0;
            if (!last_note) begin
                idx_nxt   = dir_q ? note_idx - 3'd1 : note_idx + 3'd1;
                f_nxt     = note_freq(idx_nxt);
                state_nxt = S_PLAY;
            end else if (loop) begin
                idx_nxt   = dir_q ? 3'd7 : 3'd0;
                f_nxt     = note_freq(idx_nxt);
                state_nxt = S_PLAY;
            end else begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
        end

        // Abort overrides everything above; frequency and index stay put.
        if (stop) begin
            state_nxt = S_IDLE;
            presc_nxt = '0;
            ms_nxt    = '0;
            dur_nxt   = dur;
            dir_nxt   = dir_q;
            idx_nxt   = note_idx;
            f_nxt     = f_dHz;
            done_nxt  = 1'b0;
        end

        gate_nxt = (state_nxt == S_PLAY);
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            ms_cnt   <= '0;
            dur      <= 16'd1;
            dir_q    <= 1'b0;
            note_idx <= 3'd0;
            f_dHz    <= 32'd2616;
            gate     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            ms_cnt   <= ms_nxt;
            dur      <= dur_nxt;
            dir_q    <= dir_nxt;
            note_idx <= idx_nxt;
            f_dHz    <= f_nxt;
            gate     <= gate_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_scale_sequencer.sv
// Bench for scale_sequencer: a gapped and a gapless build share the same stimulus
// and are compared every cycle against a time-based model of the scale.
module tb_scale_sequencer;

    localparam int DIV = 4;
    localparam int FREQ [8] = '{2616, 2937, 3296, 3492, 3920, 4400, 4939, 5233};

    logic        clk = 1'b0;
    logic        rst, start, stop, loop, dir;
    logic [15:0] note_ms;
    logic [31:0] f_a, f_b;
    logic [2:0]  idx_a, idx_b;
    logic        gate_a, gate_b, busy_a, busy_b, done_a, done_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    scale_sequencer #(.DIV(DIV), .GAP_MS(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .dir(dir),
        .note_ms(note_ms), .f_dHz(f_a), .gate(gate_a), .note_idx(idx_a),
        .busy(busy_a), .done(done_a)
    );

    scale_sequencer #(.DIV(DIV), .GAP_MS(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .dir(dir),
        .note_ms(note_ms), .f_dHz(f_b), .gate(gate_b), .note_idx(idx_b),
        .busy(busy_b), .done(done_b)
    );

    // Model: t counts cycles since the current pass began; each note occupies
    // (dur + gap) * DIV cycles, of which the first dur * DIV are sounding.
    typedef struct {
        bit active;
        int t;
        int dur;
        bit dir;
        int idx;
        int f;
        bit done;
        int gap;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t mdl_reset(int gap);
        mdl_t r;
        r.active = 0; r.t = 0; r.dur = 1; r.dir = 0;
        r.idx = 0; r.f = FREQ[0]; r.done = 0; r.gap = gap;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit r, bit st, bit sp, bit lp, bit d, int nm);
        int len;
        if (r) return mdl_reset(s.gap);
        s.done = 0;
        if (sp) begin
            s.active = 0;
        end else if (!s.active) begin
            if (st) begin
                s.active = 1; s.t = 0; s.dir = d;
                s.dur = (nm == 0) ? 1 : nm;
                s.idx = d ? 7 : 0;
                s.f = FREQ[s.idx];
            end
        end else begin
            len = (s.dur + s.gap) * DIV;
            s.t++;
            if (s.t == 8 * len) begin
                if (lp) s.t = 0;
                else begin
                    s.active = 0;
                    s.done = 1;
                end
            end
            if (s.active) begin
                s.idx = s.dir ? 7 - s.t / len : s.t / len;
                s.f = FREQ[s.idx];
            end
        end
        return s;
    endfunction

    function automatic bit mdl_gate(mdl_t s);
        return s.active && ((s.t % ((s.dur + s.gap) * DIV)) < s.dur * DIV);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            m[i] = mdl_step(m[i], rst, start, stop, loop, dir, int'(note_ms));
        #1;
        check("a.f_dHz", f_a, m[0].f);
        check("a.note_idx", 32'(idx_a), m[0].idx);
        check("a.gate", 32'(gate_a), 32'(mdl_gate(m[0])));
        check("a.busy", 32'(busy_a), 32'(m[0].active));
        check("a.done", 32'(done_a), 32'(m[0].done));
        check("b.f_dHz", f_b, m[1].f);
        check("b.note_idx", 32'(idx_b), m[1].idx);
        check("b.gate", 32'(gate_b), 32'(mdl_gate(m[1])));
        check("b.busy", 32'(busy_b), 32'(m[1].active));
        check("b.done", 32'(done_b), 32'(m[1].done));
        if (f_a == 32'd0 || f_b == 32'd0) begin
            vectors++;
            miscompares++;
            $display("FAIL f_dHz_zero @%0t: got 0, expected nonzero", $time);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start(input bit d, input int nm);
        dir = d; note_ms = 16'(nm); start = 1;
        step();
        start = 0;
    endtask

    int done_cnt;

    initial begin
        m[0] = mdl_reset(1);
        m[1] = mdl_reset(0);
        rst = 1; start = 0; stop = 0; loop = 0; dir = 0; note_ms = 16'd2;
        run(2);
        rst = 0;
        run(2);

        // Ascending single shot: done lands exactly 96 cycles after the start edge.
        pulse_start(0, 2);
        done_cnt = 0;
        for (int i = 1; i <= 96; i++) begin
            step();
            if (done_a) done_cnt = i;
        end
        check("asc_done_cycle", done_cnt, 96);
        run(4);

        pulse_start(1, 2);
        run(100);

        // Loop for one full pass, then release loop during the second pass.
        loop = 1;
        pulse_start(0, 2);
        run(130);
        loop = 0;
        run(80);

        // Abort during note 3 with start also high.
        pulse_start(0, 2);
        run(38);
        check("abort_pre_idx", 32'(idx_a), 3);
        stop = 1; start = 1;
        step();
        check("abort_f_held", f_a, 3492);
        stop = 0; start = 0;
        run(5);
        pulse_start(0, 2);
        check("restart_f", f_a, 2616);
        run(100);

        pulse_start(0, 0);
        run(70);

        // start held through a whole scale restarts on the done cycle.
        start = 1; note_ms = 16'd1;
        run(150);
        start = 0;
        run(70);

        // Reset while in the first gap.
        pulse_start(1, 2);
        run(9);
        rst = 1;
        step();
        rst = 0;
        run(3);

        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 9) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            dir     = $urandom_range(0, 1);
            note_ms = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) loop = ~loop;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
